// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the fetch sequencer.
// Optional performance counters are enabled with FETCH_SEQ_PERF_EN.
package fetch_sequencer_pkg;

    typedef enum logic [2:0] {
        FETCH,
        WAIT,
        EXEC,
        HALT,
        FAULT
    } fseq_state_t;

    localparam int          INSTR_BYTES = 4;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

    function automatic logic is_aligned(input logic [63:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory request/response channel between the sequencer (master)
// and the instruction memory (slave).
interface fetch_sequencer_if;

    logic        imem_req_valid;
    logic [63:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;

    modport master (
        output imem_req_valid,
        output imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        input  imem_rsp_err
    );

    modport slave (
        input  imem_req_valid,
        input  imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data,
        output imem_rsp_err
    );

endinterface

// File: rtl/fetch_sequencer_perf_cnt.sv
// Free-running cycle and retired-instruction counters for the fetch sequencer;
// only instantiated when FETCH_SEQ_PERF_EN is defined.
module fseq_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_en_i,
    input  logic        retire_i,
    output logic [63:0] cycle_cnt_o,
    output logic [63:0] retired_cnt_o
);

    logic [63:0] cycle_cnt_q, cycle_cnt_d;
    logic [63:0] retired_cnt_q, retired_cnt_d;

    // Both counters wrap naturally at 2^64.
    always_comb begin
        cycle_cnt_d   = count_en_i ? cycle_cnt_q + 64'd1 : cycle_cnt_q;
        retired_cnt_d = retire_i ? retired_cnt_q + 64'd1 : retired_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_cnt_q   <= '0;
            retired_cnt_q <= '0;
        end else begin
            cycle_cnt_q   <= cycle_cnt_d;
            retired_cnt_q <= retired_cnt_d;
        end
    end

    assign cycle_cnt_o   = cycle_cnt_q;
    assign retired_cnt_o = retired_cnt_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch/execute control FSM: fetches, holds PC, gates regfile writeback.
// Define FETCH_SEQ_PERF_EN to add the cycle_cnt / retired_cnt outputs.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic                clk,
    input  logic                rst,
    fetch_sequencer_if.master   imem,
    output logic [31:0]         instr,
    output logic                instr_valid,
    output logic                wb_en,
    input  logic                branch_taken,
    input  logic [63:0]         branch_target,
    input  logic                halt_req,
    output logic [63:0]         pc,
    output logic                halted,
    output logic                fault,
    output logic [63:0]         fault_addr
`ifdef FETCH_SEQ_PERF_EN
    ,
    output logic [63:0]         cycle_cnt,
    output logic [63:0]         retired_cnt
`endif
);

    fseq_state_t state_q, state_d;
    logic [63:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [63:0] fault_addr_q, fault_addr_d;
    logic        branch_misaligned;

    assign branch_misaligned = branch_taken && !is_aligned(branch_target);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FETCH: if (imem.imem_req_ready) state_d = WAIT;
            WAIT: begin
                if (imem.imem_rsp_valid) begin
                    state_d = imem.imem_rsp_err ? FAULT : EXEC;
                end
            end
            EXEC: begin
                if (branch_misaligned) state_d = FAULT;
                else if (halt_req)     state_d = HALT;
                else                   state_d = FETCH;
            end
            HALT:    state_d = HALT;
            FAULT:   state_d = FAULT;
            default: state_d = FAULT;
        endcase
    end

    always_comb begin
        imem.imem_req_valid = 1'b0;
        imem.imem_req_addr  = pc_q;
        instr_valid         = 1'b0;
        wb_en               = 1'b0;
        halted              = 1'b0;
        fault               = 1'b0;
        unique case (state_q)
            FETCH: imem.imem_req_valid = 1'b1;
            EXEC: begin
                instr_valid = 1'b1;
                wb_en       = 1'b1;
            end
            HALT:    halted = 1'b1;
            FAULT:   fault  = 1'b1;
            default: ;
        endcase
    end

    // PC, instruction and fault-address updates follow the same state decode.
    always_comb begin
        pc_d         = pc_q;
        instr_d      = instr_q;
        fault_addr_d = fault_addr_q;
        unique case (state_q)
            WAIT: begin
                if (imem.imem_rsp_valid) begin
                    if (imem.imem_rsp_err) fault_addr_d = pc_q;
                    else                   instr_d      = imem.imem_rsp_data;
                end
            end
            EXEC: begin
                if (branch_misaligned) fault_addr_d = branch_target;
                else if (branch_taken) pc_d         = branch_target;
                else                   pc_d         = pc_q + 64'(INSTR_BYTES);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q         <= RESET_PC;
            instr_q      <= NOP_INSTR;
            fault_addr_q <= '0;
        end else begin
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            fault_addr_q <= fault_addr_d;
        end
    end

    assign pc         = pc_q;
    assign instr      = instr_q;
    assign fault_addr = fault_addr_q;

`ifdef FETCH_SEQ_PERF_EN
    logic count_en;
    logic retire;

    assign count_en = (state_q != HALT) && (state_q != FAULT);
    assign retire   = (state_q == EXEC) && !branch_misaligned;

    fseq_perf_cnt u_perf_cnt (
        .clk           (clk),
        .rst           (rst),
        .count_en_i    (count_en),
        .retire_i      (retire),
        .cycle_cnt_o   (cycle_cnt),
        .retired_cnt_o (retired_cnt)
    );
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed self-checking bench for fetch_sequencer; inputs change and outputs
// are sampled on the falling clock edge.
module tb_fetch_sequencer;
    import fetch_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        instr_valid;
    logic        wb_en;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic        halt_req;
    logic [63:0] pc;
    logic        halted;
    logic        fault;
    logic [63:0] fault_addr;
`ifdef FETCH_SEQ_PERF_EN
    logic [63:0] cycle_cnt;
    logic [63:0] retired_cnt;
`endif

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    fetch_sequencer_if bus ();

    fetch_sequencer #(.RESET_PC(64'h0)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem          (bus),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .wb_en         (wb_en),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .halt_req      (halt_req),
        .pc            (pc),
        .halted        (halted),
        .fault         (fault),
        .fault_addr    (fault_addr)
`ifdef FETCH_SEQ_PERF_EN
        ,
        .cycle_cnt     (cycle_cnt),
        .retired_cnt   (retired_cnt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive_idle();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        bus.imem_rsp_err   = 1'b0;
        branch_taken       = 1'b0;
        branch_target      = 64'h0;
        halt_req           = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_idle();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // From FETCH: optional stall, handshake, one WAIT cycle, then response.
    task automatic fetch_to_exec(input string tag, input logic [63:0] addr,
                                 input logic [31:0] data, input int stall, input logic err);
        check({tag, ".req_valid"}, 64'(bus.imem_req_valid), 64'd1);
        check({tag, ".req_addr"}, bus.imem_req_addr, addr);
        bus.imem_req_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            check({tag, ".held_valid"}, 64'(bus.imem_req_valid), 64'd1);
            check({tag, ".held_addr"}, bus.imem_req_addr, addr);
        end
        bus.imem_req_ready = 1'b1;
        @(negedge clk);
        bus.imem_req_ready = 1'b0;
        check({tag, ".wait_req_valid"}, 64'(bus.imem_req_valid), 64'd0);
        check({tag, ".wait_instr_valid"}, 64'(instr_valid), 64'd0);
        check({tag, ".wait_wb_en"}, 64'(wb_en), 64'd0);
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = data;
        bus.imem_rsp_err   = err;
        @(negedge clk);
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_err   = 1'b0;
        if (!err) begin
            check({tag, ".exec_instr_valid"}, 64'(instr_valid), 64'd1);
            check({tag, ".exec_wb_en"}, 64'(wb_en), 64'd1);
            check({tag, ".exec_instr"}, 64'(instr), 64'(data));
        end
    endtask

    task automatic exec_step(input logic taken, input logic [63:0] target, input logic halt);
        branch_taken  = taken;
        branch_target = target;
        halt_req      = halt;
        @(negedge clk);
        branch_taken  = 1'b0;
        branch_target = 64'h0;
        halt_req      = 1'b0;
    endtask

    initial begin
        // 1: reset values, then three straight-line instructions
        do_reset();
        check("rst.req_valid", 64'(bus.imem_req_valid), 64'd1);
        check("rst.pc", pc, 64'h0);
        check("rst.instr", 64'(instr), 64'h13);
        check("rst.instr_valid", 64'(instr_valid), 64'd0);
        check("rst.wb_en", 64'(wb_en), 64'd0);
        check("rst.halted", 64'(halted), 64'd0);
        check("rst.fault", 64'(fault), 64'd0);
        check("rst.fault_addr", fault_addr, 64'h0);
`ifdef FETCH_SEQ_PERF_EN
        check("rst.cycle_cnt", cycle_cnt, 64'd0);
        check("rst.retired_cnt", retired_cnt, 64'd0);
`endif
        fetch_to_exec("t1.i0", 64'h0, 32'h0010_0093, 0, 1'b0);
        exec_step(1'b0, 64'h0, 1'b0);
        fetch_to_exec("t1.i1", 64'h4, 32'h0020_0113, 0, 1'b0);
        exec_step(1'b0, 64'h0, 1'b0);
        fetch_to_exec("t1.i2", 64'h8, 32'h0030_0193, 0, 1'b0);
        exec_step(1'b0, 64'h0, 1'b0);
        check("t1.next_addr", bus.imem_req_addr, 64'hC);
        check("t1.next_wb_en", 64'(wb_en), 64'd0);
`ifdef FETCH_SEQ_PERF_EN
        check("t1.retired_cnt", retired_cnt, 64'd3);
        check("t1.cycle_cnt", cycle_cnt, 64'd9);
`endif

        // 2: request stalled five cycles
        do_reset();
        fetch_to_exec("t2", 64'h0, 32'hDEAD_BEEF, 5, 1'b0);
        check("t2.pc", pc, 64'h0);

        // 3: aligned branch, then misaligned branch
        do_reset();
        fetch_to_exec("t3.i0", 64'h0, 32'h0000_0063, 0, 1'b0);
        exec_step(1'b1, 64'h100, 1'b0);
        check("t3.pc_redirect", pc, 64'h100);
        fetch_to_exec("t3.i1", 64'h100, 32'h0000_0463, 0, 1'b0);
        exec_step(1'b1, 64'h102, 1'b0);
        check("t3.fault", 64'(fault), 64'd1);
        check("t3.fault_addr", fault_addr, 64'h102);
        check("t3.pc_kept", pc, 64'h100);
        check("t3.req_valid", 64'(bus.imem_req_valid), 64'd0);
        check("t3.wb_en", 64'(wb_en), 64'd0);
`ifdef FETCH_SEQ_PERF_EN
        check("t3.retired_cnt", retired_cnt, 64'd1);
`endif

        // 4: bus error on the third fetch
        do_reset();
        fetch_to_exec("t4.i0", 64'h0, 32'h1111_1111, 0, 1'b0);
        exec_step(1'b0, 64'h0, 1'b0);
        fetch_to_exec("t4.i1", 64'h4, 32'h2222_2222, 0, 1'b0);
        exec_step(1'b0, 64'h0, 1'b0);
        fetch_to_exec("t4.i2", 64'h8, 32'h3333_3333, 0, 1'b1);
        check("t4.fault", 64'(fault), 64'd1);
        check("t4.fault_addr", fault_addr, 64'h8);
        check("t4.instr_kept", 64'(instr), 64'h2222_2222);
        for (int i = 0; i < 3; i++) begin
            check("t4.req_valid", 64'(bus.imem_req_valid), 64'd0);
            check("t4.instr_valid", 64'(instr_valid), 64'd0);
            @(negedge clk);
        end

        // 5: halt in the second EXEC
        do_reset();
        fetch_to_exec("t5.i0", 64'h0, 32'h0000_0013, 0, 1'b0);
        exec_step(1'b0, 64'h0, 1'b0);
        fetch_to_exec("t5.i1", 64'h4, 32'h0000_0013, 0, 1'b0);
        exec_step(1'b0, 64'h0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("t5.halted", 64'(halted), 64'd1);
            check("t5.req_valid", 64'(bus.imem_req_valid), 64'd0);
            @(negedge clk);
        end
        check("t5.pc", pc, 64'h8);
`ifdef FETCH_SEQ_PERF_EN
        check("t5.retired_cnt", retired_cnt, 64'd2);
        check("t5.cycle_cnt", cycle_cnt, 64'd6);
`endif

        // 6: reset during WAIT, then during EXEC
        do_reset();
        fetch_to_exec("t6.i0", 64'h0, 32'h0000_0013, 0, 1'b0);
        exec_step(1'b0, 64'h0, 1'b0);
        bus.imem_req_ready = 1'b1;
        @(negedge clk);
        bus.imem_req_ready = 1'b0;
        check("t6.in_wait", 64'(bus.imem_req_valid), 64'd0);
        rst = 1'b1;
        #1;
        check("t6.wait_rst_req_valid", 64'(bus.imem_req_valid), 64'd1);
        check("t6.wait_rst_pc", pc, 64'h0);
        check("t6.wait_rst_wb_en", 64'(wb_en), 64'd0);
`ifdef FETCH_SEQ_PERF_EN
        check("t6.wait_rst_cycle_cnt", cycle_cnt, 64'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        fetch_to_exec("t6.i1", 64'h0, 32'h0000_0013, 0, 1'b0);
        exec_step(1'b0, 64'h0, 1'b0);
        fetch_to_exec("t6.i2", 64'h4, 32'hABCD_0123, 0, 1'b0);
        rst = 1'b1;
        #1;
        check("t6.exec_rst_wb_en", 64'(wb_en), 64'd0);
        check("t6.exec_rst_instr_valid", 64'(instr_valid), 64'd0);
        check("t6.exec_rst_pc", pc, 64'h0);
        check("t6.exec_rst_instr", 64'(instr), 64'h13);
        check("t6.exec_rst_req_valid", 64'(bus.imem_req_valid), 64'd1);
`ifdef FETCH_SEQ_PERF_EN
        check("t6.exec_rst_cycle_cnt", cycle_cnt, 64'd0);
        check("t6.exec_rst_retired_cnt", retired_cnt, 64'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        fetch_to_exec("t6.recover", 64'h0, 32'h0000_0013, 0, 1'b0);

        // 7: pc+4 wraps at the top of the address space
        do_reset();
        fetch_to_exec("t7.i0", 64'h0, 32'h0000_0063, 0, 1'b0);
        exec_step(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
        fetch_to_exec("t7.i1", 64'hFFFF_FFFF_FFFF_FFFC, 32'h0000_0013, 0, 1'b0);
        exec_step(1'b0, 64'h0, 1'b0);
        check("t7.wrap_pc", pc, 64'h0);

        // 8: halt together with a valid branch applies the redirect first
        do_reset();
        fetch_to_exec("t8.i0", 64'h0, 32'h0000_0063, 0, 1'b0);
        exec_step(1'b1, 64'h40, 1'b1);
        check("t8.halted", 64'(halted), 64'd1);
        check("t8.pc", pc, 64'h40);
        check("t8.fault", 64'(fault), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
